// File: rtl/axi_dma_pkg.sv
// Definitions shared by the AXI DMA read and write command generators.
package axi_dma_pkg;

  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ARM   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4
  } cmd_state_e;

  // log2 of bytes per beat; DATA_WDTH is a power of two from 32 to 512
  function automatic int clog2_bpb(input int data_wdth);
    int bpb;
    int r;
    bpb = data_wdth / 8;
    r   = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < bpb) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_cmd_gen_if.sv
// Command input and burst-issue port of the read command generator.
// slave: the generator itself; master: the command source plus the downstream read stage.
interface axi_rd_cmd_gen_if #(
  parameter int ADDR_WDTH = 32,
  parameter int LEN_WDTH  = 24
);
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic [ADDR_WDTH-1:0] cmd_addr;
  logic [LEN_WDTH-1:0]  cmd_len;
  logic                 rstart_vld;
  logic                 rstart_rdy;
  logic [ADDR_WDTH-1:0] raddr;
  logic [7:0]           rburst_len;

  modport master (
    output cmd_vld, cmd_addr, cmd_len, rstart_rdy,
    input  cmd_rdy, rstart_vld, raddr, rburst_len
  );

  modport slave (
    input  cmd_vld, cmd_addr, cmd_len, rstart_rdy,
    output cmd_rdy, rstart_vld, raddr, rburst_len
  );
endinterface

// File: rtl/axi_burst_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST, beats left in the 4 KB page).
module axi_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int DATA_WDTH = 32,
  parameter int LEN_WDTH  = 24,
  parameter int MAX_BURST = 256
) (
  input  logic [11:0]         page_off,
  input  logic [LEN_WDTH-1:0] rem,
  output logic [8:0]          beats
);

  localparam int BPB_LOG2 = clog2_bpb(DATA_WDTH);
  localparam int CW       = (LEN_WDTH > 13) ? LEN_WDTH : 13;

  logic [12:0]   page_left;
  logic [12:0]   to4k;
  logic [CW-1:0] rem_x;
  logic [8:0]    rem_lim;

  always_comb begin
    // page_left is 1..4096, so an aligned address always yields to4k >= 1
    page_left = 13'(PAGE_BYTES) - {1'b0, page_off};
    to4k      = page_left >> BPB_LOG2;
    rem_x     = CW'(rem);
    rem_lim   = (rem_x > CW'(MAX_BURST)) ? 9'(MAX_BURST) : rem_x[8:0];
    beats     = ({4'b0, rem_lim} > to4k) ? to4k[8:0] : rem_lim;
  end

endmodule

// File: rtl/axi_rd_cmd_gen.sv
// Splits a DMA read command into AXI bursts (<= MAX_BURST beats, no 4 KB crossing)
// and hands them one at a time to the downstream read stage.
module axi_rd_cmd_gen
  import axi_dma_pkg::*;
#(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 32,
  parameter int LEN_WDTH  = 24,
  parameter int MAX_BURST = 256
) (
  input  logic                axi_clk,
  input  logic                axi_rst_n,
  input  logic                soft_rst,
  axi_rd_cmd_gen_if.slave     cmd_if,
  output logic                busy,
  output logic                done,
  output logic [15:0]         dbg_burst_cnt
);

  localparam int                   BPB_LOG2   = clog2_bpb(DATA_WDTH);
  localparam logic [ADDR_WDTH-1:0] ALIGN_MASK = ~ADDR_WDTH'((1 << BPB_LOG2) - 1);

  cmd_state_e           state_reg, state_next;
  logic [ADDR_WDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_WDTH-1:0]  rem_reg, rem_next;
  logic [8:0]           beats_reg, beats_next;
  logic [ADDR_WDTH-1:0] raddr_reg, raddr_next;
  logic [7:0]           rburst_len_reg, rburst_len_next;
  logic [15:0]          dbg_cnt_reg, dbg_cnt_next;
  logic                 done_reg, done_next;
  logic [8:0]           calc_beats;

  axi_burst_calc #(
    .DATA_WDTH (DATA_WDTH),
    .LEN_WDTH  (LEN_WDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .page_off (cur_addr_reg[11:0]),
    .rem      (rem_reg),
    .beats    (calc_beats)
  );

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      cur_addr_reg   <= '0;
      rem_reg        <= '0;
      beats_reg      <= '0;
      raddr_reg      <= '0;
      rburst_len_reg <= '0;
      dbg_cnt_reg    <= '0;
      done_reg       <= 1'b0;
    end else begin
      cur_addr_reg   <= cur_addr_next;
      rem_reg        <= rem_next;
      beats_reg      <= beats_next;
      raddr_reg      <= raddr_next;
      rburst_len_reg <= rburst_len_next;
      dbg_cnt_reg    <= dbg_cnt_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    rem_next        = rem_reg;
    beats_next      = beats_reg;
    raddr_next      = raddr_reg;
    rburst_len_next = rburst_len_reg;
    dbg_cnt_next    = dbg_cnt_reg;
    done_next       = 1'b0;

    // soft_rst abandons the command but keeps raddr/rburst_len/counter for debug
    if (soft_rst) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_if.cmd_vld) begin
            cur_addr_next = cmd_if.cmd_addr & ALIGN_MASK;
            rem_next      = cmd_if.cmd_len;
            state_next    = (cmd_if.cmd_len == '0) ? ST_DRAIN : ST_CALC;
          end
        end
        ST_CALC: begin
          beats_next = calc_beats;
          state_next = ST_ARM;
        end
        ST_ARM: begin
          // raddr/rburst_len only move here, so they are stable while rstart_vld is up
          if (cmd_if.rstart_rdy) begin
            raddr_next      = cur_addr_reg;
            rburst_len_next = beats_reg[7:0] - 8'd1;
            state_next      = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_if.rstart_rdy) begin
            cur_addr_next = cur_addr_reg + (ADDR_WDTH'(beats_reg) << BPB_LOG2);
            rem_next      = rem_reg - LEN_WDTH'(beats_reg);
            dbg_cnt_next  = dbg_cnt_reg + 16'd1;
            state_next    = (rem_reg == LEN_WDTH'(beats_reg)) ? ST_DRAIN : ST_CALC;
          end
        end
        ST_DRAIN: begin
          // downstream ready returns only after the final rlast
          if (cmd_if.rstart_rdy) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_rdy    = (state_reg == ST_IDLE);
  assign cmd_if.rstart_vld = (state_reg == ST_ISSUE);
  assign cmd_if.raddr      = raddr_reg;
  assign cmd_if.rburst_len = rburst_len_reg;
  assign busy              = (state_reg != ST_IDLE);
  assign done              = done_reg;
  assign dbg_burst_cnt     = dbg_cnt_reg;

endmodule

// File: tb/tb_axi_rd_cmd_gen.sv
// Self-checking bench: directed and random read commands against a burst-splitting model,
// with a behavioural downstream stage that drops rstart_rdy while a burst is in flight.
module tb_axi_rd_cmd_gen;

  localparam int DATA_WDTH = 32;
  localparam int ADDR_WDTH = 32;
  localparam int LEN_WDTH  = 24;
  localparam int MAX_BURST = 256;
  localparam int BPB       = DATA_WDTH / 8;

  logic        axi_clk   = 1'b0;
  logic        axi_rst_n = 1'b0;
  logic        soft_rst  = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] dbg_burst_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          rdy_cyc     = 0;
  logic [15:0] exp_cnt     = '0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];

  axi_rd_cmd_gen_if #(.ADDR_WDTH(ADDR_WDTH), .LEN_WDTH(LEN_WDTH)) bus ();

  axi_rd_cmd_gen #(
    .DATA_WDTH (DATA_WDTH),
    .ADDR_WDTH (ADDR_WDTH),
    .LEN_WDTH  (LEN_WDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_rst_n     (axi_rst_n),
    .soft_rst      (soft_rst),
    .cmd_if        (bus.slave),
    .busy          (busy),
    .done          (done),
    .dbg_burst_cnt (dbg_burst_cnt)
  );

  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference split: walk the byte range, cutting at MAX_BURST beats and 4 KB pages.
  function automatic void build_model(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int          r;
    int          to4k;
    int          b;
    exp_addr_q.delete();
    exp_len_q.delete();
    a = addr & ~32'(BPB - 1);
    r = len;
    while (r > 0) begin
      to4k = (4096 - int'(a % 32'd4096)) / BPB;
      b = r;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > to4k) b = to4k;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(8'(b - 1));
      a = a + 32'(b * BPB);
      r = r - b;
    end
  endfunction

  // first_gap >= 0 overrides the downstream latency of burst 0; abort_idx >= 0 fires
  // soft_rst while that burst is being offered.
  task automatic run_cmd(input logic [31:0] addr, input int len, input int first_gap,
                         input int abort_idx);
    int hs;
    int last_hs;
    int n;
    int gap;
    int exp_cyc;
    build_model(addr, len);
    check("cmd_rdy_idle", bus.cmd_rdy, 1);
    bus.cmd_vld  = 1'b1;
    bus.cmd_addr = addr;
    bus.cmd_len  = 24'(len);
    tick();
    hs = cyc;
    bus.cmd_vld = 1'b0;
    check("busy_after_cmd", busy, 1);
    check("cmd_rdy_low", bus.cmd_rdy, 0);
    last_hs = hs;
    for (int k = 0; k < exp_addr_q.size(); k++) begin
      n = 0;
      while (!bus.rstart_vld && n < 100) begin
        tick();
        n++;
      end
      check("vld_timeout", bus.rstart_vld, 1);
      // CALC then ARM after a handshake; ARM leaves one edge after ready is seen
      exp_cyc = (last_hs + 2 > rdy_cyc + 1) ? last_hs + 2 : rdy_cyc + 1;
      check("vld_cycle", cyc, exp_cyc);
      check("raddr", bus.raddr, exp_addr_q[k]);
      check("rburst_len", bus.rburst_len, exp_len_q[k]);
      $display("burst %0d: raddr=0x%08h rburst_len=%0d cycle=%0d", k, bus.raddr,
               bus.rburst_len, cyc);
      if (k == abort_idx) begin
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check("abort_cmd_rdy", bus.cmd_rdy, 1);
        check("abort_vld", bus.rstart_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_raddr_held", bus.raddr, exp_addr_q[k]);
        check("abort_len_held", bus.rburst_len, exp_len_q[k]);
        check("abort_cnt_held", dbg_burst_cnt, exp_cnt);
        repeat (5) begin
          tick();
          check("abort_no_done", done, 0);
          check("abort_stay_idle", bus.cmd_rdy, 1);
        end
        $display("cmd addr=0x%08h len=%0d aborted at burst %0d", addr, len, k);
        return;
      end
      tick();
      last_hs = cyc;
      exp_cnt = exp_cnt + 16'd1;
      bus.rstart_rdy = 1'b0;
      check("dbg_burst_cnt", dbg_burst_cnt, exp_cnt);
      check("vld_drop", bus.rstart_vld, 0);
      gap = (k == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, 5));
      repeat (gap) begin
        tick();
        check("stall_vld", bus.rstart_vld, 0);
        check("stall_busy", busy, 1);
        check("stall_raddr", bus.raddr, exp_addr_q[k]);
      end
      bus.rstart_rdy = 1'b1;
      rdy_cyc = cyc;
    end
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("done_timeout", done, 1);
    exp_cyc = (last_hs + 1 > rdy_cyc + 1) ? last_hs + 1 : rdy_cyc + 1;
    check("done_cycle", cyc, exp_cyc);
    check("done_cmd_rdy", bus.cmd_rdy, 1);
    check("done_busy", busy, 0);
    check("done_cnt", dbg_burst_cnt, exp_cnt);
    tick();
    check("done_single_pulse", done, 0);
    $display("cmd addr=0x%08h len=%0d bursts=%0d done cycle=%0d cnt=%0d", addr, len,
             exp_addr_q.size(), exp_cyc, dbg_burst_cnt);
  endtask

  initial begin
    logic [31:0] a;
    int          l;
    bus.cmd_vld    = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.rstart_rdy = 1'b1;
    repeat (3) tick();
    axi_rst_n = 1'b1;
    rdy_cyc   = cyc;
    tick();
    check("rst_cmd_rdy", bus.cmd_rdy, 1);
    check("rst_vld", bus.rstart_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", bus.raddr, 0);
    check("rst_rburst_len", bus.rburst_len, 0);
    check("rst_cnt", dbg_burst_cnt, 0);
    $display("reset released at cycle %0d", cyc);

    run_cmd(32'h0000_0000, 600, -1, -1);
    check("three_bursts_cnt", dbg_burst_cnt, 3);
    run_cmd(32'h0000_0FF0, 16, -1, -1);
    run_cmd(32'h0000_1003, 1, -1, -1);
    run_cmd(32'h0000_2000, 0, -1, -1);
    run_cmd(32'h0000_3000, 600, 50, -1);
    run_cmd(32'h0000_0000, 600, -1, 1);
    run_cmd(32'h0000_5000, 300, -1, -1);

    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = ($urandom & 32'hFFFF_F000) - 32'($urandom_range(0, 80));
        default: a = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
      endcase
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 900));
      run_cmd(a, l, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
